// File: rtl/dcache_responder_if.sv
// Core-side and memory-side bundles for the data-cache responder.
// Core side: request/response with stall. Memory side: valid/ready request with single-beat refill.
interface dcache_core_if;
   logic [31:0] dcache_addr;
   logic        dcache_re;
   logic [3:0]  dcache_we;
   logic [31:0] dcache_din;
   logic [31:0] dcache_dout;
   logic        stall;

   modport master (output dcache_addr, dcache_re, dcache_we, dcache_din,
                   input  dcache_dout, stall);
   modport slave  (input  dcache_addr, dcache_re, dcache_we, dcache_din,
                   output dcache_dout, stall);
endinterface

interface dcache_mem_if #(parameter int MEM_ADDR_W = 28);
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic                  mem_req_rw;
   logic [MEM_ADDR_W-1:0] mem_req_addr;
   logic                  mem_req_data_valid;
   logic                  mem_req_data_ready;
   logic [127:0]          mem_req_data_bits;
   logic [15:0]           mem_req_data_mask;
   logic                  mem_resp_valid;
   logic [127:0]          mem_resp_data;

   modport master (output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid,
                          mem_req_data_bits, mem_req_data_mask,
                   input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data);
   modport slave  (input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data_valid,
                          mem_req_data_bits, mem_req_data_mask,
                   output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data);
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped write-through, no-write-allocate data cache; read hits return in 1 cycle.
// Misses and all writes hold stall until the memory handshakes complete; requests stay stable until accepted.
module dcache_responder #(
   parameter int NUM_LINES  = 64,
   parameter int MEM_ADDR_W = 28
) (
   input  logic          clk,
   input  logic          reset,
   dcache_core_if.slave  core,
   dcache_mem_if.master  mem
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic [2:0] {IDLE, CHECK, RD_REQ, RD_WAIT, WR_REQ, WR_DATA} state_t;

   state_t                state, state_nxt;
   logic [31:2]           addr_q;
   logic [3:0]            we_q;
   logic [31:0]           din_q;
   logic                  data_done;
   logic [NUM_LINES-1:0]  valid_q;
   logic [TAG_W-1:0]      tag_ram [NUM_LINES];
   logic [127:0]          data_ram [NUM_LINES];
   logic [TAG_W-1:0]      tag_q;
   logic [127:0]          line_q;
   logic [127:0]          merged;
   logic [IDX_W-1:0]      idx_q, idx_in;
   logic                  is_wr, hit, accept, refill;
   logic [31:0]           word;

   assign idx_q  = addr_q[4 +: IDX_W];
   assign idx_in = core.dcache_addr[4 +: IDX_W];
   assign is_wr  = |we_q;
   assign hit    = valid_q[idx_q] && (tag_q == addr_q[31:4+IDX_W]);
   assign accept = !core.stall && (core.dcache_re || (|core.dcache_we));
   assign refill = (state == RD_WAIT) && mem.mem_resp_valid;
   assign word   = line_q[{addr_q[3:2], 5'b0} +: 32];

   assign mem.mem_req_addr      = addr_q[4 +: MEM_ADDR_W];
   assign mem.mem_req_data_bits = {4{din_q}};
   assign mem.mem_req_data_mask = {12'b0, we_q} << {addr_q[3:2], 2'b00};

   always_comb begin
      merged = line_q;
      for (int i = 0; i < 16; i++) begin
         if (mem.mem_req_data_mask[i]) merged[8*i +: 8] = mem.mem_req_data_bits[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CHECK;
         CHECK: begin
            if (is_wr)      state_nxt = WR_REQ;
            else if (!hit)  state_nxt = RD_REQ;
            else if (accept) state_nxt = CHECK;
            else            state_nxt = IDLE;
         end
         RD_REQ:  if (mem.mem_req_ready) state_nxt = RD_WAIT;
         RD_WAIT: if (mem.mem_resp_valid) state_nxt = CHECK;
         WR_REQ: begin
            // Data may have been taken in an earlier cycle; the request can land in either order.
            if (mem.mem_req_ready && (data_done || mem.mem_req_data_ready)) state_nxt = IDLE;
            else if (mem.mem_req_ready)                                       state_nxt = WR_DATA;
         end
         WR_DATA: if (mem.mem_req_data_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      core.stall             = 1'b1;
      core.dcache_dout       = '0;
      mem.mem_req_valid      = 1'b0;
      mem.mem_req_rw         = 1'b0;
      mem.mem_req_data_valid = 1'b0;
      case (state)
         IDLE:  core.stall = 1'b0;
         CHECK: if (!is_wr && hit) begin
            core.stall       = 1'b0;
            core.dcache_dout = word;
         end
         RD_REQ: mem.mem_req_valid = 1'b1;
         WR_REQ: begin
            mem.mem_req_valid      = 1'b1;
            mem.mem_req_rw         = 1'b1;
            mem.mem_req_data_valid = !data_done;
         end
         WR_DATA: begin
            mem.mem_req_rw         = 1'b1;
            mem.mem_req_data_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q    <= '0;
         we_q      <= '0;
         din_q     <= '0;
         data_done <= 1'b0;
         valid_q   <= '0;
      end else begin
         if (accept) begin
            addr_q <= core.dcache_addr[31:2];
            we_q   <= core.dcache_we;
            din_q  <= core.dcache_din;
         end
         if (refill) valid_q[idx_q] <= 1'b1;
         if (state == CHECK)
            data_done <= 1'b0;
         else if (state == WR_REQ && mem.mem_req_data_ready)
            data_done <= 1'b1;
      end
   end

   // Tag/data arrays are plain RAM; the read port is registered at request accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         tag_q  <= tag_ram[idx_in];
         line_q <= data_ram[idx_in];
      end else if (refill) begin
         tag_q  <= addr_q[31:4+IDX_W];
         line_q <= mem.mem_resp_data;
      end
      if (refill) begin
         tag_ram[idx_q]  <= addr_q[31:4+IDX_W];
         data_ram[idx_q] <= mem.mem_resp_data;
      end
      if (state == CHECK && is_wr && hit) data_ram[idx_q] <= merged;
   end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: vector table plus multi-cycle corner sequences.
// A small backing-store memory model answers refills and records write-through traffic.
module tb_dcache_responder;
   logic clk;
   logic reset;

   dcache_core_if             core();
   dcache_mem_if #(.MEM_ADDR_W(28)) mem();

   dcache_responder #(.NUM_LINES(64), .MEM_ADDR_W(28)) dut (
      .clk   (clk),
      .reset (reset),
      .core  (core),
      .mem   (mem)
   );

   int total = 0;
   int bad   = 0;

   int           rd_cnt = 0, wr_cnt = 0;
   logic [27:0]  last_wla;
   logic [15:0]  last_mask;
   logic [127:0] last_bits;
   logic         hold_req = 0, hold_data = 0;
   int           resp_delay = 0;
   logic         pend = 0;
   int           pend_cnt = 0;
   logic [27:0]  pend_la;
   logic [127:0] store [logic [27:0]];

   typedef struct {
      logic [31:0] addr;
      logic        re;
      logic [3:0]  we;
      logic [31:0] din;
      logic [31:0] exp_dout;
      int          exp_rd;
      int          exp_wr;
      logic [15:0] exp_mask;
   } vec_t;
   vec_t vecs [14];

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] line_of(input logic [27:0] la);
      logic [127:0] l;
      if (store.exists(la)) return store[la];
      for (int k = 0; k < 4; k++) l[32*k +: 32] = {la[15:0], 16'(k + 1)};
      return l;
   endfunction

   // Memory model: decide ready/resp on the falling edge; handshakes complete on the next rising edge.
   initial begin
      logic [127:0] cur;
      mem.mem_req_ready = 0; mem.mem_req_data_ready = 0;
      mem.mem_resp_valid = 0; mem.mem_resp_data = '0;
      forever begin
         @(negedge clk);
         mem.mem_resp_valid = 0;
         if (pend) begin
            if (pend_cnt == 0) begin
               mem.mem_resp_valid = 1;
               mem.mem_resp_data  = line_of(pend_la);
               pend = 0;
            end else pend_cnt--;
         end
         mem.mem_req_ready      = !hold_req;
         mem.mem_req_data_ready = !hold_data;
         if (reset && mem.mem_req_valid && mem.mem_req_ready && !mem.mem_req_rw) begin
            pend = 1; pend_cnt = resp_delay; pend_la = mem.mem_req_addr; rd_cnt++;
         end
         if (reset && mem.mem_req_data_valid && mem.mem_req_data_ready) begin
            wr_cnt++;
            last_wla = mem.mem_req_addr; last_mask = mem.mem_req_data_mask;
            last_bits = mem.mem_req_data_bits;
            cur = line_of(mem.mem_req_addr);
            for (int i = 0; i < 16; i++)
               if (last_mask[i]) cur[8*i +: 8] = last_bits[8*i +: 8];
            store[mem.mem_req_addr] = cur;
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic access(input logic [31:0] a, input logic r, input logic [3:0] w,
                         input logic [31:0] d, output logic [31:0] dout, output int lat);
      core.dcache_addr = a; core.dcache_re = r; core.dcache_we = w; core.dcache_din = d;
      @(posedge clk);
      @(negedge clk); #1;
      core.dcache_re = 0; core.dcache_we = 0;
      lat = 1;
      while (core.stall && lat < 200) begin
         @(negedge clk); #1;
         lat++;
      end
      dout = core.dcache_dout;
      if (core.stall) begin
         total++; bad++;
         $display("FAIL access_timeout addr=%0h: stall still 1 after %0d cycles, want 0", a, lat);
      end
   endtask

   initial begin
      logic [31:0] dout;
      int lat, rd0, wr0;
      logic stable;

      vecs[0]  = '{32'h100, 1, 4'b0000, 32'h0,        32'h00100001, 1, 0, 16'h0};
      vecs[1]  = '{32'h104, 1, 4'b0000, 32'h0,        32'h00100002, 0, 0, 16'h0};
      vecs[2]  = '{32'h104, 0, 4'b0011, 32'hAABBCCDD, 32'h0,        0, 1, 16'h0030};
      vecs[3]  = '{32'h104, 1, 4'b0000, 32'h0,        32'h0010CCDD, 0, 0, 16'h0};
      vecs[4]  = '{32'h100, 1, 4'b0000, 32'h0,        32'h00100001, 0, 0, 16'h0};
      vecs[5]  = '{32'h500, 1, 4'b0000, 32'h0,        32'h00500001, 1, 0, 16'h0};
      vecs[6]  = '{32'h100, 1, 4'b0000, 32'h0,        32'h00100001, 1, 0, 16'h0};
      vecs[7]  = '{32'h104, 1, 4'b0000, 32'h0,        32'h0010CCDD, 0, 0, 16'h0};
      vecs[8]  = '{32'h208, 0, 4'b1111, 32'h11223344, 32'h0,        0, 1, 16'h0F00};
      vecs[9]  = '{32'h208, 1, 4'b0000, 32'h0,        32'h11223344, 1, 0, 16'h0};
      vecs[10] = '{32'h20A, 1, 4'b1000, 32'h99000000, 32'h0,        0, 1, 16'h0800};
      vecs[11] = '{32'h208, 1, 4'b0000, 32'h0,        32'h99223344, 0, 0, 16'h0};
      vecs[12] = '{32'h50C, 0, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 1, 16'hF000};
      vecs[13] = '{32'h10C, 1, 4'b0000, 32'h0,        32'h00100004, 0, 0, 16'h0};

      core.dcache_addr = '0; core.dcache_re = 0; core.dcache_we = '0; core.dcache_din = '0;
      reset = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stall", core.stall, 0);
      chk("rst_dout", core.dcache_dout, 0);
      chk("rst_req_valid", mem.mem_req_valid, 0);
      chk("rst_data_valid", mem.mem_req_data_valid, 0);
      reset = 1;
      @(negedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         rd0 = rd_cnt; wr0 = wr_cnt;
         access(vecs[i].addr, vecs[i].re, vecs[i].we, vecs[i].din, dout, lat);
         chk($sformatf("v%0d_rd", i), rd_cnt - rd0, vecs[i].exp_rd);
         chk($sformatf("v%0d_wr", i), wr_cnt - wr0, vecs[i].exp_wr);
         if (vecs[i].we == 0) begin
            chk($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
            if (vecs[i].exp_rd == 0) chk($sformatf("v%0d_hitlat", i), lat, 1);
         end else begin
            chk($sformatf("v%0d_mask", i), last_mask, vecs[i].exp_mask);
            chk($sformatf("v%0d_wla", i), last_wla, vecs[i].addr[31:4]);
            chk($sformatf("v%0d_bits", i), last_bits, {4{vecs[i].din}});
         end
      end

      // Back-to-back read hits accepted while in the hit cycle
      rd0 = rd_cnt;
      core.dcache_addr = 32'h100; core.dcache_re = 1;
      @(posedge clk); @(negedge clk); #1;
      chk("b2b_stall0", core.stall, 0);
      chk("b2b_dout0", core.dcache_dout, 32'h00100001);
      core.dcache_addr = 32'h108;
      @(posedge clk); @(negedge clk); #1;
      core.dcache_re = 0;
      chk("b2b_stall1", core.stall, 0);
      chk("b2b_dout1", core.dcache_dout, 32'h00100003);
      chk("b2b_no_req", mem.mem_req_valid, 0);
      chk("b2b_rd", rd_cnt - rd0, 0);

      // Write held off by memory: request/data must stay stable, then request lands before data
      @(negedge clk); #1;
      hold_req = 1; hold_data = 1; wr0 = wr_cnt;
      core.dcache_addr = 32'h104; core.dcache_we = 4'b1111; core.dcache_din = 32'h12345678;
      @(posedge clk); @(negedge clk); #1;
      core.dcache_we = 0;
      stable = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (!(core.stall && mem.mem_req_valid && mem.mem_req_rw && mem.mem_req_data_valid &&
               mem.mem_req_addr == 28'h010 && mem.mem_req_data_mask == 16'h00F0 &&
               mem.mem_req_data_bits == {4{32'h12345678}})) stable = 0;
      end
      chk("hold_stable", stable, 1);
      hold_req = 0;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("wrdata_req_valid", mem.mem_req_valid, 0);
      chk("wrdata_data_valid", mem.mem_req_data_valid, 1);
      chk("wrdata_stall", core.stall, 1);
      hold_data = 0;
      lat = 0;
      while (core.stall && lat < 50) begin @(negedge clk); #1; lat++; end
      chk("hold_done_stall", core.stall, 0);
      chk("hold_wr", wr_cnt - wr0, 1);
      chk("hold_mask", last_mask, 16'h00F0);

      // Reset while waiting for a refill; the late response must be ignored
      resp_delay = 4; rd0 = rd_cnt;
      core.dcache_addr = 32'h300; core.dcache_re = 1;
      @(posedge clk); @(negedge clk); #1;
      core.dcache_re = 0;
      lat = 0;
      while (rd_cnt == rd0 && lat < 50) begin @(negedge clk); #1; lat++; end
      chk("rdwait_req_seen", rd_cnt - rd0, 1);
      @(negedge clk); #1;
      chk("rdwait_stall", core.stall, 1);
      reset = 0;
      #1;
      chk("midrst_stall", core.stall, 0);
      chk("midrst_dout", core.dcache_dout, 0);
      chk("midrst_req_valid", mem.mem_req_valid, 0);
      chk("midrst_data_valid", mem.mem_req_data_valid, 0);
      repeat (2) @(negedge clk);
      #1 reset = 1;
      repeat (6) @(negedge clk);
      #1;
      chk("late_resp_ignored", core.stall, 0);
      resp_delay = 0;
      rd0 = rd_cnt;
      access(32'h100, 1, 4'b0000, 32'h0, dout, lat);
      chk("postrst_miss", rd_cnt - rd0, 1);
      chk("postrst_dout", dout, 32'h00100001);
      rd0 = rd_cnt;
      access(32'h104, 1, 4'b0000, 32'h0, dout, lat);
      chk("postrst_hit_rd", rd_cnt - rd0, 0);
      chk("postrst_hit_dout", dout, 32'h12345678);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
